// File: rtl/majority_pkg.sv
`default_nettype none
// ============================================================================
// Module      : majority_pkg
// Description : Shared defaults and helpers for the majority voter.
// Revision    : 1.0  initial release
// ============================================================================
package majority_pkg;

  localparam int DEFAULT_N = 5;
  localparam int MAX_N     = 32;

  // Count width large enough to hold the value n itself.
  function automatic int calc_cw(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int popcount(input logic [MAX_N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_N; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage : majority_pkg
`default_nettype wire

// File: rtl/majority_ckt_if.sv
`default_nettype none
// ============================================================================
// Module      : majority_ckt_if
// Description : Vote input / registered result bundle for majority_ckt.
// Revision    : 1.0  initial release
// ============================================================================
interface majority_ckt_if
  import majority_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = calc_cw(N)
) ();

  logic          in_valid;
  logic [N-1:0]  a;
  logic          y;
  logic [CW-1:0] count;
  logic          out_valid;
  logic          all_ones;
  logic          all_zeros;

  modport master (
    output in_valid, a,
    input  y, count, out_valid, all_ones, all_zeros
  );

  modport slave (
    input  in_valid, a,
    output y, count, out_valid, all_ones, all_zeros
  );

endinterface : majority_ckt_if
`default_nettype wire

// File: rtl/majority_popcount.sv
`default_nettype none
// ============================================================================
// Module      : majority_popcount
// Description : Combinational balanced adder tree counting ones in a_i.
// Revision    : 1.0  initial release
// ============================================================================
module majority_popcount
  import majority_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = calc_cw(N)
) (
  input  wire logic [N-1:0]  a_i,
  output      logic [CW-1:0] count_o
);

  localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
  localparam int P      = 1 << LEVELS;

  // Inputs are zero-padded to a power of two; every node is CW wide since no
  // partial sum can exceed N.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [CW-1:0] s [P >> l];
    for (genvar j = 0; j < (P >> l); j++) begin : g_node
      if (l == 0) begin : g_leaf
        if (j < N) begin : g_bit
          assign s[j] = CW'(a_i[j]);
        end else begin : g_pad
          assign s[j] = '0;
        end
      end else begin : g_sum
        assign s[j] = g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
      end
    end
  end

  assign count_o = g_lvl[LEVELS].s[0];

endmodule : majority_popcount
`default_nettype wire

// File: rtl/majority_ckt.sv
`default_nettype none
// ============================================================================
// Module      : majority_ckt
// Description : Registered N-input strict-majority voter with count and flags.
// Revision    : 1.0  initial release
// ============================================================================
module majority_ckt
  import majority_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = calc_cw(N)
) (
  input wire logic      clk,
  input wire logic      rst,
  majority_ckt_if.slave bus
);

  localparam int THRESH = N / 2 + 1;

  logic [CW-1:0] w_count;
  logic          y_d, all_ones_d, all_zeros_d;
  logic          y_q, all_ones_q, all_zeros_q, out_valid_q;
  logic [CW-1:0] count_q;

  majority_popcount #(
    .N  (N),
    .CW (CW)
  ) u_popcount (
    .a_i     (bus.a),
    .count_o (w_count)
  );

  // Threshold of N/2+1 makes an even-N tie resolve to 0.
  always_comb begin
    y_d         = (w_count >= CW'(THRESH));
    all_ones_d  = (w_count == CW'(N));
    all_zeros_d = (w_count == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= 1'b0;
      count_q     <= '0;
      all_ones_q  <= 1'b0;
      all_zeros_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        y_q         <= y_d;
        count_q     <= w_count;
        all_ones_q  <= all_ones_d;
        all_zeros_q <= all_zeros_d;
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.count     = count_q;
  assign bus.all_ones  = all_ones_q;
  assign bus.all_zeros = all_zeros_q;
  assign bus.out_valid = out_valid_q;

endmodule : majority_ckt
`default_nettype wire

// File: tb/tb_majority_ckt.sv
`default_nettype none
// ============================================================================
// Module      : tb_majority_ckt
// Description : Directed, table-driven checks of majority_ckt (N=5 and N=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_majority_ckt;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  majority_ckt_if #(.N(5)) bus5 ();
  majority_ckt_if #(.N(4)) bus4 ();

  majority_ckt #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
  majority_ckt #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic       iv;
    logic       y;
    int         cnt;
    logic       ov;
    logic       ao;
    logic       az;
  } vec5_t;

  typedef struct {
    logic [3:0] a;
    logic       y;
    int         cnt;
    logic       ao;
    logic       az;
  } vec4_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check5(input string name, input logic y, input int cnt,
                        input logic ov, input logic ao, input logic az);
    check({name, ".y"},         int'(bus5.y),         int'(y));
    check({name, ".count"},     int'(bus5.count),     cnt);
    check({name, ".out_valid"}, int'(bus5.out_valid), int'(ov));
    check({name, ".all_ones"},  int'(bus5.all_ones),  int'(ao));
    check({name, ".all_zeros"}, int'(bus5.all_zeros), int'(az));
  endtask

  task automatic drive5(input logic [4:0] a, input logic iv);
    @(negedge clk);
    bus5.a        = a;
    bus5.in_valid = iv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec5_t tbl5 [11];
  vec4_t tbl4 [5];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus5.a = '0; bus5.in_valid = 1'b0;
    bus4.a = '0; bus4.in_valid = 1'b0;

    //           a         iv    y     cnt ov    ao    az
    tbl5[0]  = '{5'b00111, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0};
    tbl5[1]  = '{5'b00011, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    tbl5[2]  = '{5'b11111, 1'b1, 1'b1, 5, 1'b1, 1'b1, 1'b0};
    tbl5[3]  = '{5'b00000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1};
    tbl5[4]  = '{5'b10101, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0};
    tbl5[5]  = '{5'b00001, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0};
    tbl5[6]  = '{5'b00000, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0};
    tbl5[7]  = '{5'b10010, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    tbl5[8]  = '{5'b11010, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0};
    tbl5[9]  = '{5'b01000, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    tbl5[10] = '{5'b11110, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0};

    //           a        y     cnt ao    az
    tbl4[0] = '{4'b0011, 1'b0, 2, 1'b0, 1'b0};
    tbl4[1] = '{4'b0111, 1'b1, 3, 1'b0, 1'b0};
    tbl4[2] = '{4'b1001, 1'b0, 2, 1'b0, 1'b0};
    tbl4[3] = '{4'b1111, 1'b1, 4, 1'b1, 1'b0};
    tbl4[4] = '{4'b0000, 1'b0, 0, 1'b0, 1'b1};

    // Asynchronous reset with no clock edge in between.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check5("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    rst = 1'b0;

    // First vote after release: one-cycle latency.
    drive5(5'b00111, 1'b1);
    step();
    check5("first_after_reset", 1'b1, 3, 1'b1, 1'b0, 1'b0);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      int         pc;
      v  = 5'(i);
      pc = $countones(v);
      drive5(v, 1'b1);
      step();
      check($sformatf("sweep[%0d].y", i),     int'(bus5.y),         (pc >= 3) ? 1 : 0);
      check($sformatf("sweep[%0d].count", i), int'(bus5.count),     pc);
      check($sformatf("sweep[%0d].ov", i),    int'(bus5.out_valid), 1);
    end

    for (int i = 0; i < 11; i++) begin
      drive5(tbl5[i].a, tbl5[i].iv);
      step();
      check5($sformatf("tbl5[%0d]", i), tbl5[i].y, tbl5[i].cnt,
             tbl5[i].ov, tbl5[i].ao, tbl5[i].az);
    end

    // Reset mid-stream while y=1; vote presented during reset is discarded.
    drive5(5'b11100, 1'b1);
    step();
    check5("pre_reset", 1'b1, 3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check5("mid_reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    bus5.a        = 5'b11111;
    bus5.in_valid = 1'b1;
    step();
    check5("reset_held", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst           = 1'b0;
    bus5.in_valid = 1'b0;
    step();
    check5("discarded", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    drive5(5'b01110, 1'b1);
    step();
    check5("post_reset_vote", 1'b1, 3, 1'b1, 1'b0, 1'b0);
    drive5(5'b00000, 1'b0);

    // Even-N tie handling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus4.a        = tbl4[i].a;
      bus4.in_valid = 1'b1;
      step();
      check($sformatf("tbl4[%0d].y", i),     int'(bus4.y),         int'(tbl4[i].y));
      check($sformatf("tbl4[%0d].count", i), int'(bus4.count),     tbl4[i].cnt);
      check($sformatf("tbl4[%0d].ao", i),    int'(bus4.all_ones),  int'(tbl4[i].ao));
      check($sformatf("tbl4[%0d].az", i),    int'(bus4.all_zeros), int'(tbl4[i].az));
      check($sformatf("tbl4[%0d].ov", i),    int'(bus4.out_valid), 1);
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    step();
    check("n4_idle.ov", int'(bus4.out_valid), 0);
    check("n4_idle.az_hold", int'(bus4.all_zeros), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_majority_ckt
`default_nettype wire
